exe_muldiv: RTL and testbench
=============================

Name: exe_muldiv

Overview:
- Iterative multiply/divide unit in the EXE stage, directly downstream of the ID/EXE pipeline register.
- Consumes the operand pair and a mul/div opcode latched into EXE.
- Runs a 32-step shift-add multiply or restoring divide.
- Drives `stall` back to the PC, IF/ID and ID/EXE registers until the result is ready, then presents it to the EXE/MEM register for one advancing cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is required; the iteration counter is sized $clog2(XLEN)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  level: a mul/div instruction occupies EXE (already gated by the decoder)
- in_op  in  3  0=MUL (low 32), 1=MULHU (high 32, unsigned), 2=DIV, 3=DIVU, 4=REM, 5=REMU; 6,7 reserved
- in_a  in  32  operand A (dividend / multiplicand), forwarded value
- in_b  in  32  operand B (divisor / multiplier), forwarded value
- hold  in  1  downstream (MEM/WB) stall: EXE must not advance this cycle
- flush  in  1  EXE instruction is squashed (branch/jump redirect)
- busy  out  1  registered: state is not IDLE
- stall  out  1  combinational: freeze PC, IF/ID and ID/EXE this cycle
- done  out  1  registered: result valid this cycle
- result  out  32  registered result, valid when done=1

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, counter=0, busy=0, done=0, result=0, internal accumulators=0. Reset has priority over flush and in_valid, and aborts any operation in progress.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_valid & ~flush & op<=5 -> latch operands and op.
  - Signed DIV/REM: latch |a|, |b| and the result sign. Quotient sign = a[31]^b[31]; remainder sign = a[31].
  - b==0 or (signed & a==0x80000000 & b==0xFFFFFFFF) -> go directly to DONE.
  - All other ops -> CALC, counter=0.
  - op 6/7: ignored; stay IDLE.
- CALC: one radix-2 step per cycle, 32 cycles (counter 0..31), then FIX.
  - MUL/MULHU: 64-bit product accumulator, add-shift on multiplier LSB.
  - DIV/REM: restoring division on a 64-bit {rem,quot} register; subtract 33-bit, keep if non-negative.
- FIX: negate quotient/remainder per latched signs, select output word, load `result`; next state DONE.
- DONE: done=1, `result` stable.
  - hold=0 -> IDLE next edge.
  - hold=1 -> remain DONE with done and result unchanged, so the same instruction is not restarted.
- Special cases:
  - Divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU remainder=in_a.
  - Signed overflow: DIV quotient=0x80000000; REM remainder=0.
- Latency:
  - Normal op sampled at edge T (IDLE): CALC occupies T+1..T+32, FIX at T+33, done=1 at T+34. EXE occupancy is 35 cycles.
  - Special cases: done=1 at T+1.
- stall = ~flush & ( (state==IDLE & in_valid & op<=5) | state==CALC | state==FIX ).
  - stall=0 in DONE, so the ID/EXE and EXE/MEM registers advance and capture `result` on that edge (unless hold).
- flush=1 in any state -> IDLE at next edge. Same cycle: stall=0 and done forced 0. No result is produced.
- busy = (state != IDLE).
- in_a/in_b/in_op changes after the IDLE acceptance edge are ignored (operands were latched).

Test Plan:
- MUL a=7, b=0xFFFFFFFA -> done at T+34, result=0xFFFFFFD6; stall high T..T+33, low at T+34.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. DIV a=-20 (0xFFFFFFEC), b=3 -> 0xFFFFFFFA. REM same operands -> 0xFFFFFFFE.
- DIVU a=5, b=0 -> done at T+1, result=0xFFFFFFFF. REM a=0x80000000, b=0xFFFFFFFF -> done at T+1, result=0.
- Start DIVU 100/7; assert flush at T+10 -> IDLE at T+11, stall=0 during T+10, done never asserts. A following MUL 3*4 gives 12.
- Finish DIVU 100/7 with hold=1 for 3 cycles in DONE -> done and result=14 stay stable; no restart. hold=0 -> IDLE next cycle.
- Assert rst at T+5 of a MUL -> next edge: busy=0, done=0, result=0, stall=0 with in_valid=0.

Source files
------------

// File: rtl/exe_muldiv.sv
// Iterative 32-step multiply / restoring-divide unit for the EXE stage.
// Holds the front of the pipeline via stall until the result is registered.
module exe_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            hold,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            accept, is_div, is_signed;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [XLEN-1:0] quot, rem;

  assign accept    = in_valid & ~flush & (in_op <= 3'd5);
  assign is_div    = (in_op >= 3'd2);
  assign is_signed = (in_op == 3'd2) | (in_op == 3'd4);
  assign abs_a     = (is_signed & in_a[XLEN-1]) ? -in_a : in_a;
  assign abs_b     = (is_signed & in_b[XLEN-1]) ? -in_b : in_b;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: acc = {rem, quot}; trial-subtract on the shifted-left remainder.
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};

  assign quot = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    done_d   = done_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (accept) begin
          op_d  = in_op;
          cnt_d = '0;
          if (is_div) begin
            opnd_d = abs_b;
            acc_d  = {{XLEN{1'b0}}, abs_a};
            negq_d = is_signed & (in_a[XLEN-1] ^ in_b[XLEN-1]);
            negr_d = is_signed & in_a[XLEN-1];
            if (in_b == '0) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = (in_op <= 3'd3) ? ALL_ONES : in_a;
            end else if (is_signed && in_a == MIN_NEG && in_b == ALL_ONES) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = (in_op == 3'd2) ? MIN_NEG : '0;
            end else begin
              state_d = S_CALC;
            end
          end else begin
            opnd_d  = in_a;
            acc_d   = {{XLEN{1'b0}}, in_b};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q <= 3'd1) begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
          acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          3'd0:          result_d = acc_q[XLEN-1:0];
          3'd1:          result_d = acc_q[2*XLEN-1:XLEN];
          3'd2, 3'd3:    result_d = quot;
          default:       result_d = rem;
        endcase
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        if (!hold) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign stall  = ~flush & (((state_q == S_IDLE) & in_valid & (in_op <= 3'd5)) |
                            (state_q == S_CALC) | (state_q == S_FIX));
  assign done   = done_q & ~flush;
  assign result = result_q;
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: driver pushes expected results, monitor checks done/result.
module tb_exe_muldiv;
  logic        clk = 1'b0;
  logic        rst, in_valid, hold, flush;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        busy, stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  exe_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .hold(hold), .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each done cycle is compared; the entry retires only on an advancing cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got result %h expected no done", result);
        end else begin
          chk("result", result, exp_q[0]);
          if (!hold) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int h);
    int k;
    bit seen, stall_bad;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    exp_q.push_back(exp);
    #1;
    chk("stall_accept", {31'd0, stall}, 32'd1);
    @(posedge clk);
    k = 0; seen = 1'b0; stall_bad = 1'b0;
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      in_a = ~a; in_b = a ^ b;
      #1;
      if (done) seen = 1'b1;
      else if (!stall) stall_bad = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", k, lat);
    chk("stall_busy", {31'd0, stall_bad}, 32'd0);
    chk("stall_done", {31'd0, stall}, 32'd0);
    in_valid = 1'b0;
    if (h > 0) begin
      hold = 1'b1;
      repeat (h) @(negedge clk);
      hold = 1'b0;
      #1;
      chk("done_held", {31'd0, done}, 32'd1);
    end
    @(negedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    $display("op=%0d a=%h b=%h exp=%h latency=%0d hold=%0d", op, a, b, exp, k, h);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    in_op = 3'd0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_done",   {31'd0, done},  32'd0);
    chk("rst_stall",  {31'd0, stall}, 32'd0);
    chk("rst_result", result, 32'd0);

    run_op(3'd0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 34, 0);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    run_op(3'd2, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 34, 0);
    run_op(3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 34, 0);
    run_op(3'd2, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 0);
    run_op(3'd4, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 0);
    run_op(3'd3, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run_op(3'd5, 32'd5,        32'd0,        32'd5,        1,  0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run_op(3'd3, 32'd100,      32'd7,        32'd14,       34, 3);
    run_op(3'd5, 32'hFFFFFFFF, 32'd10,       32'd5,        34, 0);

    // Reserved opcode: no stall, never leaves IDLE.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd6; in_a = 32'd9; in_b = 32'd9;
    #1;
    chk("rsvd_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;

    // Flush mid-divide: abandon without a result, then a fresh MUL.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd3; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_done",  {31'd0, done},  32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_idle", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, 0);

    // Reset mid-multiply: everything clears.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd5; in_b = 32'd6;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, busy},  32'd0);
    chk("mid_rst_done",   {31'd0, done},  32'd0);
    chk("mid_rst_stall",  {31'd0, stall}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    repeat (40) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
